icache_direct_mapped: RTL

- Direct-mapped instruction cache between the CPU fetch stage and the 128-bit block instruction memory.
- Serves 32-bit instructions to the CPU and asserts busywait on a miss.
- On a miss, fetches one 16-byte block from instruction memory, which takes 16 cycles and returns data byte-serially into a 128-bit bus.
- Has an invalidate-all input for OS-initiated cache switching.

---
 rtl/icache_pkg.sv | 35 +++
 rtl/icache_if.sv | 38 +++
 rtl/icache_line_array.sv | 62 ++++++
 rtl/icache_direct_mapped.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_pkg
// Purpose  : Shared types and constants for the direct-mapped instruction
//            cache: FSM state encoding, block geometry and address helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package icache_pkg;

    localparam int LINE_BYTES = 16;                  // bytes per cache block
    localparam int OFFSET_W   = 4;                   // byte offset bits in a block
    localparam int WORD_SEL_W = 2;                   // word select bits in a block
    localparam int ADDR_W     = 32;                  // CPU byte address width
    localparam int BLOCK_W    = 8 * LINE_BYTES;      // block data width (128)
    localparam int BLK_ADDR_W = ADDR_W - OFFSET_W;   // block address width (28)

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        FILL     = 2'd2
    } state_t;

    // Block address (tag and index together) of a byte address.
    function automatic logic [BLK_ADDR_W-1:0] get_block_addr(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:OFFSET_W];
    endfunction

    // Word offset within the block.
    function automatic logic [WORD_SEL_W-1:0] get_word_sel(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W-1:OFFSET_W-WORD_SEL_W];
    endfunction

endpackage : icache_pkg
`default_nettype wire

// File: rtl/icache_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_if
// Purpose  : Bundles the CPU fetch port and the block instruction-memory port
//            of the instruction cache.
// Signals  : read/address/invalidate      CPU -> cache
//            instruction/busywait         cache -> CPU
//            mem_read/mem_address         cache -> memory
//            mem_readdata/mem_busywait    memory -> cache
// Modports : slave  - the cache side
//            master - the environment (CPU + memory) side
// Revision : 1.0 - initial release
// ============================================================================
interface icache_if;
    import icache_pkg::*;

    logic                  read;
    logic [ADDR_W-1:0]     address;
    logic                  invalidate;
    logic [31:0]           instruction;
    logic                  busywait;
    logic                  mem_read;
    logic [BLK_ADDR_W-1:0] mem_address;
    logic [BLOCK_W-1:0]    mem_readdata;
    logic                  mem_busywait;

    modport slave (
        input  read, address, invalidate, mem_readdata, mem_busywait,
        output instruction, busywait, mem_read, mem_address
    );

    modport master (
        output read, address, invalidate, mem_readdata, mem_busywait,
        input  instruction, busywait, mem_read, mem_address
    );

endinterface : icache_if
`default_nettype wire

// File: rtl/icache_line_array.sv
`default_nettype none
// ============================================================================
// Module   : icache_line_array
// Purpose  : Valid/tag/data storage of the cache. One write port, one
//            combinational read port, and an invalidate-all that overrides a
//            simultaneous write's valid bit.
// Ports    : clock, reset (async active-low, clears valid bits only)
//            invalidate_all                clear every valid bit next edge
//            wr_en/wr_index/wr_tag/wr_data install a line
//            rd_index -> rd_valid/rd_tag/rd_data
// Revision : 1.0 - initial release
// ============================================================================
module icache_line_array
    import icache_pkg::*;
#(
    parameter int LINES   = 8,
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 25
) (
    input  wire logic               clock,
    input  wire logic               reset,
    input  wire logic               invalidate_all,
    input  wire logic               wr_en,
    input  wire logic [INDEX_W-1:0] wr_index,
    input  wire logic [TAG_W-1:0]   wr_tag,
    input  wire logic [BLOCK_W-1:0] wr_data,
    input  wire logic [INDEX_W-1:0] rd_index,
    output logic                    rd_valid,
    output logic [TAG_W-1:0]        rd_tag,
    output logic [BLOCK_W-1:0]      rd_data
);

    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [BLOCK_W-1:0] r_data [LINES];

    // Invalidate has priority so an OS cache switch never leaves a line
    // that was being filled at the same edge marked valid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else if (invalidate_all) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are qualified by the valid bit.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            r_tag[wr_index]  <= wr_tag;
            r_data[wr_index] <= wr_data;
        end
    end

    assign rd_valid = r_valid[rd_index];
    assign rd_tag   = r_tag[rd_index];
    assign rd_data  = r_data[rd_index];

endmodule : icache_line_array
`default_nettype wire

// File: rtl/icache_direct_mapped.sv
`default_nettype none
// ============================================================================
// Module   : icache_direct_mapped
// Purpose  : Direct-mapped instruction cache. Zero-cycle hits, 18-cycle miss
//            (IDLE + 16 MEM_READ + FILL) fetching a 16-byte block from a
//            byte-serial block memory. Invalidate-all for cache switching.
// Ports    : clock  - system clock, rising edge
//            reset  - asynchronous active-low reset
//            bus    - icache_if.slave (CPU fetch port + memory port)
// Revision : 1.0 - initial release
// ============================================================================
module icache_direct_mapped
    import icache_pkg::*;
#(
    parameter int LINES   = 8,
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 25
) (
    input  wire logic clock,
    input  wire logic reset,
    icache_if.slave   bus
);

    state_t                r_state;
    state_t                w_next_state;
    logic [BLK_ADDR_W-1:0] r_miss_addr;
    logic [31:0]           r_instruction;

    logic [BLK_ADDR_W-1:0] w_block_addr;
    logic [WORD_SEL_W-1:0] w_word_sel;
    logic [INDEX_W-1:0]    w_index;
    logic [TAG_W-1:0]      w_tag;
    logic [INDEX_W-1:0]    w_miss_index;
    logic [TAG_W-1:0]      w_miss_tag;
    logic                  w_line_valid;
    logic [TAG_W-1:0]      w_line_tag;
    logic [BLOCK_W-1:0]    w_line_data;
    logic                  w_hit;
    logic                  w_start_miss;
    logic [31:0]           w_word;
    logic                  w_fill;
    logic                  w_mem_read;
    logic [BLK_ADDR_W-1:0] w_mem_address;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_block_addr = get_block_addr(bus.address);
    assign w_word_sel   = get_word_sel(bus.address);
    assign w_index      = w_block_addr[INDEX_W-1:0];
    assign w_tag        = w_block_addr[BLK_ADDR_W-1:INDEX_W];

    // The fill uses the latched miss address, so the CPU address is free
    // to wander (or read to drop) without corrupting the line.
    assign w_miss_index = r_miss_addr[INDEX_W-1:0];
    assign w_miss_tag   = r_miss_addr[BLK_ADDR_W-1:INDEX_W];

    icache_line_array #(
        .LINES   (LINES),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_lines (
        .clock          (clock),
        .reset          (reset),
        .invalidate_all (bus.invalidate),
        .wr_en          (w_fill),
        .wr_index       (w_miss_index),
        .wr_tag         (w_miss_tag),
        .wr_data        (bus.mem_readdata),
        .rd_index       (w_index),
        .rd_valid       (w_line_valid),
        .rd_tag         (w_line_tag),
        .rd_data        (w_line_data)
    );

    // ------------------------------------------------------------------
    // Hit path
    // ------------------------------------------------------------------
    assign w_hit        = w_line_valid && (w_line_tag == w_tag);
    assign w_start_miss = bus.read && !w_hit;
    assign w_word       = w_line_data[{w_word_sel, 5'b00000} +: 32];

    // Last delivered instruction is held while not hitting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_instruction <= '0;
        end else if (w_hit) begin
            r_instruction <= w_word;
        end
    end

    assign bus.instruction = w_hit ? w_word : r_instruction;

    // Gated by reset so the stall drops immediately when reset hits mid-miss.
    assign bus.busywait = reset && bus.read && (!w_hit || (r_state != IDLE));

    // ------------------------------------------------------------------
    // Miss FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_miss_addr <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == IDLE) && w_start_miss) begin
                r_miss_addr <= w_block_addr;
            end
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_mem_read    = 1'b0;
        w_mem_address = '0;
        w_fill        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_miss) begin
                    w_next_state = MEM_READ;
                end
            end
            MEM_READ: begin
                w_mem_read    = 1'b1;
                w_mem_address = r_miss_addr;
                // mem_busywait low marks the edge that lands byte 15.
                if (!bus.mem_busywait) begin
                    w_next_state = FILL;
                end
            end
            FILL: begin
                w_fill       = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // mem_read comes straight from the state register, so it is never high
    // outside MEM_READ and drops asynchronously with reset.
    assign bus.mem_read    = w_mem_read;
    assign bus.mem_address = w_mem_address;

endmodule : icache_direct_mapped
`default_nettype wire
